// File: rtl/spi_frame_master.sv
// SPI master (mode 0) that sends one 56-bit frame per spi_run rising edge:
// 8-bit command, 16-bit address, 32-bit data, MSB first. The last 32 bits
// sampled from miso are presented on miso_data at frame end.
// Optional macro SPI_CS_GAP_EN adds a GAP state that keeps cs_n high for
// CS_GAP cycles after each frame and remembers one start edge seen meanwhile.
module spi_frame_master #(
  parameter int HALF_DIV = 5,
  parameter int CS_GAP   = 4
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        spi_run,
  input  logic [7:0]  spi_com,
  input  logic [15:0] spi_addr,
  input  logic [31:0] mosi_data,
  output logic [31:0] miso_data,
  output logic        spi_done,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_DONE
`ifdef SPI_CS_GAP_EN
    , S_GAP
`endif
  } state_t;

  localparam logic [7:0] LP_PH_LAST  = 8'(HALF_DIV - 1);
  localparam logic [5:0] LP_BIT_LAST = 6'd55;
`ifdef SPI_CS_GAP_EN
  localparam logic [7:0] LP_GAP_LAST = 8'(CS_GAP - 1);
`endif

  // Reject parameter values the 8-bit counters cannot represent.
  if (HALF_DIV < 2 || HALF_DIV > 255) begin : g_bad_half_div
    $error("HALF_DIV must be in 2..255");
  end
  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("CS_GAP must be in 1..255");
  end

  state_t      r_state, w_state;
  logic [7:0]  r_phase, w_phase;
  logic [5:0]  r_bit, w_bit;
  logic [55:0] r_shift, w_shift;
  logic [31:0] r_cap, w_cap;
  logic [31:0] r_miso_data, w_miso_data;
  logic        r_sclk, w_sclk;
  logic        r_cs_n, w_cs_n;
  logic        r_mosi, w_mosi;
  logic        r_done, w_done;
  logic        r_run, r_run_d;
  logic        w_rise, w_launch;
`ifdef SPI_CS_GAP_EN
  logic [7:0]  r_gap, w_gap;
  logic        r_pend, w_pend;
`endif

  assign w_rise    = r_run & ~r_run_d;
  assign miso_data = r_miso_data;
  assign spi_done  = r_done;
  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;

  // Register spi_run and its previous value for rising-edge detection.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_run_d <= 1'b0;
    end else begin
      r_run   <= spi_run;
      r_run_d <= r_run;
    end
  end

  // State, counters, shift/capture registers and registered pin outputs.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_cap       <= '0;
      r_miso_data <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SPI_CS_GAP_EN
      r_gap       <= '0;
      r_pend      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_cap       <= w_cap;
      r_miso_data <= w_miso_data;
      r_sclk      <= w_sclk;
      r_cs_n      <= w_cs_n;
      r_mosi      <= w_mosi;
      r_done      <= w_done;
`ifdef SPI_CS_GAP_EN
      r_gap       <= w_gap;
      r_pend      <= w_pend;
`endif
    end
  end

  // Next-state and next-output logic; frame launch is shared by IDLE and GAP.
  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_bit       = r_bit;
    w_shift     = r_shift;
    w_cap       = r_cap;
    w_miso_data = r_miso_data;
    w_sclk      = r_sclk;
    w_cs_n      = r_cs_n;
    w_mosi      = r_mosi;
    w_done      = 1'b0;
    w_launch    = 1'b0;
`ifdef SPI_CS_GAP_EN
    w_gap       = r_gap;
    w_pend      = r_pend;
`endif
    case (r_state)
      S_IDLE: w_launch = w_rise;
      S_LOW: begin
        if (r_phase == LP_PH_LAST) begin
          w_phase = '0;
          w_sclk  = 1'b1;
          w_state = S_HIGH;
        end else begin
          w_phase = r_phase + 8'd1;
        end
      end
      S_HIGH: begin
        if (r_phase == '0) w_cap = {r_cap[30:0], miso};
        if (r_phase == LP_PH_LAST) begin
          w_phase = '0;
          w_sclk  = 1'b0;
          if (r_bit == LP_BIT_LAST) begin
            w_state = S_HOLD;
          end else begin
            w_state = S_LOW;
            w_bit   = r_bit + 6'd1;
            w_shift = {r_shift[54:0], 1'b0};
            w_mosi  = r_shift[54];
          end
        end else begin
          w_phase = r_phase + 8'd1;
        end
      end
      S_HOLD: begin
        if (r_phase == LP_PH_LAST) begin
          w_phase     = '0;
          w_state     = S_DONE;
          w_cs_n      = 1'b1;
          w_mosi      = 1'b0;
          w_done      = 1'b1;
          w_miso_data = r_cap;
        end else begin
          w_phase = r_phase + 8'd1;
        end
      end
`ifdef SPI_CS_GAP_EN
      S_DONE: begin
        w_state = S_GAP;
        w_gap   = '0;
        w_pend  = 1'b0;
      end
      S_GAP: begin
        if (w_rise) w_pend = 1'b1;
        if (r_gap == LP_GAP_LAST) begin
          w_state  = S_IDLE;
          w_launch = r_pend | w_rise;
        end else begin
          w_gap = r_gap + 8'd1;
        end
      end
`else
      S_DONE: w_state = S_IDLE;
`endif
      default: w_state = S_IDLE;
    endcase
    if (w_launch) begin
      w_state = S_LOW;
      w_phase = '0;
      w_bit   = '0;
      w_shift = {spi_com, spi_addr, mosi_data};
      w_cs_n  = 1'b0;
      w_sclk  = 1'b0;
      w_mosi  = spi_com[7];
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master (default build, macro undefined).
// A cycle-level model derives the expected pin waveforms from frame start time.
module tb_spi_frame_master;

  localparam int H  = 5;
  localparam int FL = 113 * H;

  logic        clk_100m = 1'b0;
  logic        rst_n    = 1'b0;
  logic        spi_run  = 1'b0;
  logic [7:0]  spi_com  = '0;
  logic [15:0] spi_addr = '0;
  logic [31:0] mosi_data = '0;
  logic [31:0] miso_data;
  logic        spi_done, sclk, cs_n, mosi, miso;

  always #5 clk_100m = ~clk_100m;

  spi_frame_master #(.HALF_DIV(H), .CS_GAP(4)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .spi_run(spi_run),
    .spi_com(spi_com), .spi_addr(spi_addr), .mosi_data(mosi_data),
    .miso_data(miso_data), .spi_done(spi_done), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // miso source: 0 = random slave vector, 1 = loopback, 2 = tied 0, 3 = tied 1
  int          mode = 0;
  logic [55:0] mvec = '0;
  logic        vbit = 1'b0;
  assign miso = (mode == 1) ? mosi : (mode == 2) ? 1'b0 : (mode == 3) ? 1'b1 : vbit;

  // Slave transmit side: first bit at cs_n fall, next bit on each sclk fall.
  bit in_frame = 0;
  int sidx = 0;
  always @(negedge cs_n or negedge sclk or posedge cs_n) begin
    if (cs_n) in_frame = 0;
    else if (!in_frame) begin
      in_frame = 1; sidx = 0; vbit = mvec[55];
    end else begin
      sidx++;
      if (sidx < 56) vbit = mvec[55 - sidx];
    end
  end

  // Slave receive side: shift mosi on sclk rising edges.
  logic [55:0] rx = '0;
  int          np = 0;
  always @(posedge sclk or negedge cs_n) begin
    if (!cs_n && !sclk) begin rx = '0; np = 0; end
    else if (sclk && !cs_n) begin rx = {rx[54:0], mosi}; np++; end
  end

  // Model: frame start time derived from sampled spi_run history.
  int          cyc = 0, cycE = 0;
  bit          active = 0, run_prev = 0;
  logic [55:0] frame = '0;
  logic [31:0] exp_md = '0;
  always @(posedge clk_100m) begin
    bit free;
    cyc++;
    if (!rst_n) begin
      run_prev = 0; active = 0;
    end else begin
      free = !active || (cyc - cycE >= FL + 2);
      if (spi_run && !run_prev && free) begin active = 1; cycE = cyc; end
      if (active && cyc == cycE + 1) frame = {spi_com, spi_addr, mosi_data};
      run_prev = spi_run;
    end
  end

  // Compare process plus cs_n/spi_done bookkeeping.
  int  dcnt = 0, cs_run = 0, cs_last = 0, hi_run = 0, hi_last = 0;
  bit  started = 0;
  always @(negedge clk_100m) begin
    int t;
    bit inf, ecs, esck, edn;
    t = cyc - cycE;
    if (!rst_n) begin
      exp_md = '0;
      chk("pins_rst", {cs_n, sclk, spi_done, mosi}, 4'b1000);
      chk("miso_data_rst", miso_data, 0);
    end else begin
      inf  = active && t >= 1 && t <= FL;
      ecs  = !inf;
      esck = active && t >= 1 && t <= 112 * H && ((t - 1) % (2 * H)) >= H;
      edn  = active && t == FL + 1;
      if (edn) case (mode)
        0: exp_md = mvec[31:0];
        1: exp_md = frame[31:0];
        2: exp_md = 32'h0;
        default: exp_md = 32'hFFFF_FFFF;
      endcase
      chk("pins{cs_n,sclk,done}", {cs_n, sclk, spi_done}, {ecs, esck, edn});
      if (active && t >= 1 && t <= 112 * H)
        chk("mosi_bit", mosi, frame[55 - (t - 1) / (2 * H)]);
      else if (!inf)
        chk("mosi_idle", mosi, 0);
      chk("miso_data", miso_data, exp_md);
    end
    if (spi_done) dcnt++;
    if (!cs_n) begin
      if (cs_run == 0 && started) hi_last = hi_run;
      cs_run++; hi_run = 0; started = 1;
    end else begin
      if (cs_run > 0) cs_last = cs_run;
      cs_run = 0; hi_run++;
    end
  end

  int c0 = 0;

  // Call right after a negedge; raises spi_run, drops it a cycle later unless hold.
  task automatic start(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d,
                       input int md, input bit hold);
    spi_com = c; spi_addr = a; mosi_data = d; mode = md;
    mvec = {$urandom(), $urandom()};
    spi_run = 1'b1; c0 = cyc;
    @(negedge clk_100m);
    if (!hold) spi_run = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < FL + 40; i++) begin
      @(negedge clk_100m);
      if (spi_done) begin lat = cyc - c0; break; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no spi_done, expected one within %0d cycles", FL + 40);
    end
  endtask

  initial begin
    int lat, d0;
    repeat (3) @(negedge clk_100m);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_done", spi_done, 0);
    chk("rst_miso_data", miso_data, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);

    // Write frame with a known pattern; hand-computed expectations.
    start(8'h02, 16'h1234, 32'hDEADBEEF, 0, 0);
    wait_done(lat);
    chk("done_latency", lat, 567);
    @(negedge clk_100m);
    chk("slave_rx", rx, 56'h02_1234_DEADBEEF);
    chk("sclk_pulses", np, 56);
    chk("cs_low_cycles", cs_last, 565);
    chk("miso_data_vec", miso_data, {32'h0, mvec[31:0]});

    // Loopback and tied miso.
    start(8'h5C, 16'hBEEF, 32'hA5A55A5A, 1, 0); wait_done(lat);
    @(negedge clk_100m); chk("loopback", miso_data, 32'hA5A55A5A);
    start(8'hFF, 16'hFFFF, 32'hFFFFFFFF, 2, 0); wait_done(lat);
    @(negedge clk_100m); chk("miso_zero", miso_data, 32'h0);
    start(8'h00, 16'h0000, 32'h0, 3, 0); wait_done(lat);
    @(negedge clk_100m); chk("miso_ones", miso_data, 32'hFFFFFFFF);

    // spi_run held high through the frame: exactly one frame.
    d0 = dcnt;
    start(8'h11, 16'h2222, 32'h33334444, 0, 1);
    repeat (2 * FL + 20) @(negedge clk_100m);
    spi_run = 1'b0;
    chk("held_run_dones", dcnt - d0, 1);

    // Second rising edge mid-frame is ignored.
    d0 = dcnt;
    start(8'h21, 16'h4321, 32'h87654321, 0, 0);
    repeat (200) @(negedge clk_100m);
    spi_run = 1'b1; @(negedge clk_100m); spi_run = 1'b0;
    repeat (2 * FL) @(negedge clk_100m);
    chk("midframe_edge_dones", dcnt - d0, 1);

    // Back-to-back frames: second edge raised during DONE.
    d0 = dcnt;
    start(8'h03, 16'h0102, 32'h0BADF00D, 1, 0); wait_done(lat);
    start(8'h04, 16'h0304, 32'hCAFEBABE, 1, 0); wait_done(lat);
    @(negedge clk_100m);
    chk("b2b_dones", dcnt - d0, 2);
    chk("b2b_cs_gap_ge1", hi_last >= 1, 1);
    chk("b2b_second_rx", rx, 56'h04_0304_CAFEBABE);

    // Data stability: inputs change after the latch cycle.
    start(8'h02, 16'hAAAA, 32'h12345678, 0, 0);
    @(negedge clk_100m);
    mosi_data = 32'hFFFF0000; spi_com = 8'h99; spi_addr = 16'h5555;
    wait_done(lat);
    @(negedge clk_100m);
    chk("stable_rx", rx, 56'h02_AAAA_12345678);

    // Edges near the frame end: model decides whether each one starts a frame.
    for (int k = 0; k < 6; k++) begin
      start(8'($urandom()), 16'($urandom()), $urandom(), 0, 0);
      repeat (FL - 4 + $urandom_range(0, 7)) @(negedge clk_100m);
      spi_run = 1'b1; @(negedge clk_100m); spi_run = 1'b0;
      repeat (2 * FL + 20) @(negedge clk_100m);
    end

    // Random frames across all miso sources.
    for (int k = 0; k < 6; k++) begin
      start(8'($urandom()), 16'($urandom()), $urandom(), int'($urandom_range(0, 3)), 0);
      wait_done(lat);
      repeat ($urandom_range(1, 5)) @(negedge clk_100m);
    end

    // Asynchronous reset at bit 20.
    start(8'h7E, 16'h1357, 32'h2468ACE0, 0, 0);
    for (int i = 0; i < FL && np < 20; i++) @(negedge clk_100m);
    chk("reached_bit20", np >= 20, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cs_n", cs_n, 1);
    chk("async_rst_sclk", sclk, 0);
    d0 = dcnt;
    repeat (FL) @(negedge clk_100m);
    chk("rst_no_done", dcnt - d0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);
    start(8'hA0, 16'h0F0F, 32'h600DCAFE, 0, 0);
    wait_done(lat);
    chk("post_rst_latency", lat, 567);
    @(negedge clk_100m);
    chk("post_rst_rx", rx, 56'hA0_0F0F_600DCAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
